// File: rtl/sparc_control_unit.sv
// sparc_control_unit: hard-wired control sequencer for the SPARC datapath.
// Sequences fetch, ALU, SETHI, CALL, Bicc, LD/ST word and trap entry.
// Optional macro CU_MFC_TIMEOUT_EN adds a memory-wait timeout that traps.
module sparc_control_unit #(
  parameter logic [5:0] ALU_OP_ADD   = 6'b000000,
  parameter logic [5:0] ALU_OP_SETHI = 6'b111111
`ifdef CU_MFC_TIMEOUT_EN
  , parameter int MFC_TIMEOUT = 16
`endif
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR,
  input  logic [31:0] PSR,
  input  logic        MFC,
  input  logic        IntReq,
  output logic        IRE, MDRE, TBRE, nPCE, PCE, MARE, PSRE, RFE, WIME, tQE, ALUE,
  output logic        ClrPC, nPCClr, IRClr, tQClr,
  output logic        nPC_ADD, nPC_ADDSEL, TB_ADD, MFA, MOP_SEL, AOP_SEL, RA_SEL,
  output logic        DISP_SEL, BAUX, ttAUX, PSR_SEL, TBA_SEL, ET, PSR_SUPER, PSR_PREV_SUP,
  output logic [1:0]  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL,
  output logic [5:0]  OP1,
  output logic [5:0]  tQ_IN,
  output logic [4:0]  State,
  output logic        Error
);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_ALU, S_ALUCC, S_SETHI, S_CALL, S_BICC,
    S_LD0, S_LD1, S_LD2, S_ST0, S_ST1, S_ST2,
    S_ADV, S_TRAP0, S_TRAP1, S_TRAP2, S_TRAP3, S_ERROR
  } state_e;

  state_e state_q, state_d;
  logic   etBit, condBase, branchTaken, mfcTimeout;
  logic   unusedBits;

  assign etBit      = PSR[5];
  assign State      = state_q;
  assign unusedBits = ^{IR[29], IR[18:14], IR[12:0], PSR[31:24], PSR[19:8], PSR[6], PSR[4:0]};

  // Bicc condition: low three bits pick the test, bit 3 inverts it (0000 never, 1000 always)
  always_comb begin
    condBase = 1'b0;
    unique case (IR[27:25])
      3'b000: condBase = 1'b0;
      3'b001: condBase = PSR[22];
      3'b010: condBase = PSR[22] | (PSR[23] ^ PSR[21]);
      3'b011: condBase = PSR[23] ^ PSR[21];
      3'b100: condBase = PSR[20] | PSR[22];
      3'b101: condBase = PSR[20];
      3'b110: condBase = PSR[23];
      3'b111: condBase = PSR[21];
      default: condBase = 1'b0;
    endcase
    branchTaken = condBase ^ IR[28];
  end

`ifdef CU_MFC_TIMEOUT_EN
  logic [4:0] waitCnt_q, waitCnt_d;
  logic       inWait, enteringWait;

  assign inWait       = (state_q == S_FETCH1) || (state_q == S_LD1) || (state_q == S_ST2);
  assign enteringWait = (state_d != state_q) &&
                        ((state_d == S_FETCH1) || (state_d == S_LD1) || (state_d == S_ST2));
  assign mfcTimeout   = inWait && !MFC && (waitCnt_q == 5'(MFC_TIMEOUT));

  // Wait counter restarts on entry to a memory wait and counts cycles spent without MFC
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (enteringWait)
      waitCnt_d = 5'd0;
    else if (inWait && !MFC)
      waitCnt_d = waitCnt_q + 5'd1;
  end

  // Wait counter register
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) waitCnt_q <= 5'd0;
    else      waitCnt_q <= waitCnt_d;
  end
`else
  assign mfcTimeout = 1'b0;
`endif

  // State register; a low Clr drops straight into RESET so no partial writes follow
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  // Next-state and output decode; everything idle unless the current state claims it
  always_comb begin
    IRE = 1'b0; MDRE = 1'b0; TBRE = 1'b0; nPCE = 1'b0; PCE = 1'b0; MARE = 1'b0;
    PSRE = 1'b0; RFE = 1'b0; WIME = 1'b0; tQE = 1'b0; ALUE = 1'b0;
    ClrPC = 1'b1; nPCClr = 1'b1; IRClr = 1'b1; tQClr = 1'b1;
    nPC_ADD = 1'b0; nPC_ADDSEL = 1'b0; TB_ADD = 1'b0; MFA = 1'b0; MOP_SEL = 1'b0;
    AOP_SEL = 1'b0; RA_SEL = 1'b0; DISP_SEL = 1'b0; BAUX = 1'b0; ttAUX = 1'b0;
    PSR_SEL = 1'b0; TBA_SEL = 1'b0; ET = 1'b0; PSR_SUPER = 1'b0; PSR_PREV_SUP = 1'b0;
    nPC_SEL = 2'b00; ALU_SEL = 2'b00; CIN_SEL = 2'b00; RC_SEL = 2'b00;
    MAR_SEL = 2'b00; MDR_SEL = 2'b00; OP1 = 6'b000000; tQ_IN = 6'b000000;
    Error = 1'b0;
    state_d = state_q;

    unique case (state_q)
      S_RESET: begin
        ClrPC = 1'b0; nPCClr = 1'b0; IRClr = 1'b0; tQClr = 1'b0;
        state_d = S_FETCH0;
      end
      S_FETCH0: begin
        MAR_SEL = 2'b01; MARE = 1'b1;
        state_d = S_FETCH1;
      end
      S_FETCH1: begin
        MFA = 1'b1; MOP_SEL = 1'b1; OP1 = 6'b000000; MDR_SEL = 2'b00; MDRE = MFC;
        if (MFC) state_d = S_FETCH2;
        else if (mfcTimeout) begin
          tQ_IN[0] = 1'b1; tQE = 1'b1;
          state_d = etBit ? S_TRAP0 : S_ERROR;
        end
      end
      S_FETCH2: begin
        IRE = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (IntReq && etBit) begin
          tQ_IN[2] = 1'b1; tQE = 1'b1;
          state_d = S_TRAP0;
        end else if (IR[31:30] == 2'b10) state_d = S_ALU;
        else if (IR[31:30] == 2'b01) state_d = S_CALL;
        else if (IR[31:30] == 2'b00 && IR[24:22] == 3'b100) state_d = S_SETHI;
        else if (IR[31:30] == 2'b00 && IR[24:22] == 3'b010) state_d = S_BICC;
        else if (IR[31:30] == 2'b11 && IR[24:19] == 6'b000000) state_d = S_LD0;
        else if (IR[31:30] == 2'b11 && IR[24:19] == 6'b000100) state_d = S_ST0;
        else begin
          tQ_IN[1] = 1'b1; tQE = 1'b1;
          state_d = etBit ? S_TRAP0 : S_ERROR;
        end
      end
      S_ALU, S_ALUCC: begin
        AOP_SEL = 1'b0; RA_SEL = 1'b0; ALU_SEL = IR[13] ? 2'b01 : 2'b00;
        CIN_SEL = 2'b10; RC_SEL = 2'b00;
        if (state_q == S_ALU) begin
          ALUE = 1'b1; RFE = 1'b1;
          state_d = IR[23] ? S_ALUCC : S_ADV;
        end else begin
          PSRE = 1'b1; PSR_SEL = 1'b0;
          state_d = S_ADV;
        end
      end
      S_SETHI: begin
        AOP_SEL = 1'b1; OP1 = ALU_OP_SETHI; ALU_SEL = 2'b11; ALUE = 1'b1;
        CIN_SEL = 2'b10; RC_SEL = 2'b00; RFE = 1'b1;
        state_d = S_ADV;
      end
      S_CALL: begin
        CIN_SEL = 2'b00; RC_SEL = 2'b11; RFE = 1'b1; BAUX = 1'b1; DISP_SEL = 1'b1;
        nPC_SEL = 2'b10; nPCE = 1'b1; PCE = 1'b1;
        state_d = S_FETCH0;
      end
      S_BICC: begin
        if (branchTaken) begin
          BAUX = 1'b1; DISP_SEL = 1'b0; nPC_SEL = 2'b10; nPCE = 1'b1; PCE = 1'b1;
          state_d = S_FETCH0;
        end else state_d = S_ADV;
      end
      S_LD0, S_ST0: begin
        AOP_SEL = 1'b1; OP1 = ALU_OP_ADD; ALU_SEL = IR[13] ? 2'b01 : 2'b00;
        ALUE = 1'b1; MAR_SEL = 2'b00; MARE = 1'b1;
        state_d = (state_q == S_LD0) ? S_LD1 : S_ST1;
      end
      S_LD1: begin
        MFA = 1'b1; MOP_SEL = 1'b0; MDR_SEL = 2'b00; MDRE = MFC;
        if (MFC) state_d = S_LD2;
        else if (mfcTimeout) begin
          tQ_IN[0] = 1'b1; tQE = 1'b1;
          state_d = etBit ? S_TRAP0 : S_ERROR;
        end
      end
      S_LD2: begin
        CIN_SEL = 2'b11; RC_SEL = 2'b00; RFE = 1'b1;
        state_d = S_ADV;
      end
      S_ST1: begin
        RA_SEL = 1'b1; MDR_SEL = 2'b01; MDRE = 1'b1;
        state_d = S_ST2;
      end
      S_ST2: begin
        MFA = 1'b1; MOP_SEL = 1'b0;
        if (MFC) state_d = S_ADV;
        else if (mfcTimeout) begin
          tQ_IN[0] = 1'b1; tQE = 1'b1;
          state_d = etBit ? S_TRAP0 : S_ERROR;
        end
      end
      S_ADV, S_TRAP3: begin
        PCE = 1'b1; nPCE = 1'b1; nPC_SEL = 2'b00; nPC_ADD = 1'b1; nPC_ADDSEL = 1'b0;
        state_d = S_FETCH0;
      end
      S_TRAP0: begin
        CIN_SEL = 2'b00; RC_SEL = 2'b10; RFE = 1'b1;
        state_d = S_TRAP1;
      end
      S_TRAP1: begin
        CIN_SEL = 2'b01; RC_SEL = 2'b01; RFE = 1'b1; TBRE = 1'b1; TBA_SEL = 1'b0; ttAUX = 1'b0;
        state_d = S_TRAP2;
      end
      S_TRAP2: begin
        PSR_SEL = 1'b1; ET = 1'b0; PSR_SUPER = 1'b1; PSR_PREV_SUP = PSR[7]; PSRE = 1'b1;
        nPC_SEL = 2'b01; nPCE = 1'b1; tQClr = 1'b0;
        state_d = S_TRAP3;
      end
      S_ERROR: begin
        Error = 1'b1;
        state_d = S_ERROR;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_sparc_control_unit.sv
// tb_sparc_control_unit: directed checks of the SPARC control sequencer.
module tb_sparc_control_unit;

  localparam logic [4:0] ST_RESET = 5'd0,  ST_F0 = 5'd1,  ST_F1 = 5'd2,  ST_F2 = 5'd3;
  localparam logic [4:0] ST_DEC = 5'd4,    ST_ALU = 5'd5, ST_ALUCC = 5'd6, ST_SETHI = 5'd7;
  localparam logic [4:0] ST_CALL = 5'd8,   ST_BICC = 5'd9, ST_LD0 = 5'd10, ST_LD1 = 5'd11;
  localparam logic [4:0] ST_LD2 = 5'd12,   ST_ST0 = 5'd13, ST_ST1 = 5'd14, ST_ST2 = 5'd15;
  localparam logic [4:0] ST_ADV = 5'd16,   ST_T0 = 5'd17, ST_T1 = 5'd18, ST_T2 = 5'd19;
  localparam logic [4:0] ST_T3 = 5'd20,    ST_ERR = 5'd21;

  logic        Clk, Clr, MFC, IntReq;
  logic [31:0] IR, PSR;
  logic        IRE, MDRE, TBRE, nPCE, PCE, MARE, PSRE, RFE, WIME, tQE, ALUE;
  logic        ClrPC, nPCClr, IRClr, tQClr;
  logic        nPC_ADD, nPC_ADDSEL, TB_ADD, MFA, MOP_SEL, AOP_SEL, RA_SEL;
  logic        DISP_SEL, BAUX, ttAUX, PSR_SEL, TBA_SEL, ET, PSR_SUPER, PSR_PREV_SUP;
  logic [1:0]  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL;
  logic [5:0]  OP1, tQ_IN;
  logic [4:0]  State;
  logic        Error;

  int testsRun = 0;
  int testsFailed = 0;

  sparc_control_unit dut (
    .Clk(Clk), .Clr(Clr), .IR(IR), .PSR(PSR), .MFC(MFC), .IntReq(IntReq),
    .IRE(IRE), .MDRE(MDRE), .TBRE(TBRE), .nPCE(nPCE), .PCE(PCE), .MARE(MARE),
    .PSRE(PSRE), .RFE(RFE), .WIME(WIME), .tQE(tQE), .ALUE(ALUE),
    .ClrPC(ClrPC), .nPCClr(nPCClr), .IRClr(IRClr), .tQClr(tQClr),
    .nPC_ADD(nPC_ADD), .nPC_ADDSEL(nPC_ADDSEL), .TB_ADD(TB_ADD), .MFA(MFA),
    .MOP_SEL(MOP_SEL), .AOP_SEL(AOP_SEL), .RA_SEL(RA_SEL), .DISP_SEL(DISP_SEL),
    .BAUX(BAUX), .ttAUX(ttAUX), .PSR_SEL(PSR_SEL), .TBA_SEL(TBA_SEL), .ET(ET),
    .PSR_SUPER(PSR_SUPER), .PSR_PREV_SUP(PSR_PREV_SUP),
    .nPC_SEL(nPC_SEL), .ALU_SEL(ALU_SEL), .CIN_SEL(CIN_SEL), .RC_SEL(RC_SEL),
    .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .OP1(OP1), .tQ_IN(tQ_IN),
    .State(State), .Error(Error)
  );

  // Free-running 10 ns clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] psr, input logic mfc, input logic intReq);
    IR = ir; PSR = psr; MFC = mfc; IntReq = intReq;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expectState(input string tag, input logic [4:0] exp);
    tick();
    checkOutput(tag, {27'd0, State}, {27'd0, exp});
  endtask

  // Zero-wait fetch from FETCH0 up to DECODE
  task automatic fetchSeq(input string tag);
    expectState({tag, "_f1"}, ST_F1);
    checkOutput({tag, "_f1_mdre"}, {31'd0, MDRE}, 32'd1);
    expectState({tag, "_f2"}, ST_F2);
    checkOutput({tag, "_f2_ire"}, {31'd0, IRE}, 32'd1);
    expectState({tag, "_dec"}, ST_DEC);
  endtask

  // Bicc vectors: instruction, PSR, expected taken
  logic [31:0] bIr    [5] = '{32'h02800003, 32'h02800003, 32'h12800003, 32'h06800003, 32'h06800003};
  logic [31:0] bPsr   [5] = '{32'h00400020, 32'h00000020, 32'h00000020, 32'h00800020, 32'h00A00020};
  logic        bTaken [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    Clr = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_state", {27'd0, State}, {27'd0, ST_RESET});
    checkOutput("reset_clrs", {28'd0, ClrPC, nPCClr, IRClr, tQClr}, 32'h0);
    checkOutput("reset_mare", {31'd0, MARE}, 32'd0);
    Clr = 1'b1;
    expectState("boot_f0", ST_F0);
    checkOutput("f0_mare", {29'd0, MARE, MAR_SEL}, {29'd0, 1'b1, 2'b01});

    // add r1,5,r1: ALU then ADV, six cycles
    applyStimulus(32'h82006005, 32'h20, 1'b1, 1'b0);
    fetchSeq("alu");
    expectState("alu_st", ST_ALU);
    checkOutput("alu_sel", {26'd0, ALU_SEL, CIN_SEL, RC_SEL}, {26'd0, 2'b01, 2'b10, 2'b00});
    checkOutput("alu_en", {30'd0, RFE, ALUE}, 32'h3);
    expectState("alu_adv", ST_ADV);
    checkOutput("adv_en", {28'd0, PCE, nPCE, nPC_ADD, nPC_SEL == 2'b00}, 32'hF);
    expectState("alu_back", ST_F0);

    // addcc: extra ALUCC cycle
    applyStimulus(32'h82806005, 32'h20, 1'b1, 1'b0);
    fetchSeq("alucc");
    expectState("alucc_alu", ST_ALU);
    expectState("alucc_st", ST_ALUCC);
    checkOutput("alucc_en", {29'd0, PSRE, ALUE, RFE}, 32'h4);
    expectState("alucc_adv", ST_ADV);
    expectState("alucc_back", ST_F0);

    // Bicc table
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bIr[i], bPsr[i], 1'b1, 1'b0);
      fetchSeq("bicc");
      expectState("bicc_st", ST_BICC);
      checkOutput("bicc_pce", {31'd0, PCE}, {31'd0, bTaken[i]});
      if (bTaken[i]) begin
        checkOutput("bicc_npcsel", {28'd0, nPC_SEL, nPCE, BAUX}, {28'd0, 2'b10, 2'b11});
      end else begin
        expectState("bicc_adv", ST_ADV);
      end
      expectState("bicc_back", ST_F0);
    end

    // SETHI and CALL
    applyStimulus(32'h03000001, 32'h20, 1'b1, 1'b0);
    fetchSeq("sethi");
    expectState("sethi_st", ST_SETHI);
    checkOutput("sethi_op", {24'd0, OP1, ALU_SEL}, {24'd0, 6'b111111, 2'b11});
    expectState("sethi_adv", ST_ADV);
    expectState("sethi_back", ST_F0);
    applyStimulus(32'h40000010, 32'h20, 1'b1, 1'b0);
    fetchSeq("call");
    expectState("call_st", ST_CALL);
    checkOutput("call_sel", {27'd0, RC_SEL, nPC_SEL, DISP_SEL}, {27'd0, 2'b11, 2'b10, 1'b1});
    expectState("call_back", ST_F0);

    // LD with three wait cycles in LD1
    applyStimulus(32'hC2006004, 32'h20, 1'b1, 1'b0);
    fetchSeq("ld");
    expectState("ld0", ST_LD0);
    checkOutput("ld0_en", {29'd0, MARE, ALUE, AOP_SEL}, 32'h7);
    MFC = 1'b0;
    for (int w = 0; w < 3; w++) begin
      expectState("ld1_wait", ST_LD1);
      checkOutput("ld1_mdre_lo", {31'd0, MDRE}, 32'd0);
    end
    tick();
    MFC = 1'b1;
    #1;
    checkOutput("ld1_last", {27'd0, State}, {27'd0, ST_LD1});
    checkOutput("ld1_mdre_hi", {31'd0, MDRE}, 32'd1);
    expectState("ld2", ST_LD2);
    checkOutput("ld2_wr", {27'd0, RFE, RC_SEL, CIN_SEL}, {27'd0, 1'b1, 2'b00, 2'b11});
    expectState("ld_adv", ST_ADV);
    expectState("ld_back", ST_F0);

    // Async reset in the middle of an LD1 wait
    fetchSeq("ldr");
    expectState("ldr_ld0", ST_LD0);
    MFC = 1'b0;
    expectState("ldr_ld1", ST_LD1);
    #1 Clr = 1'b0;
    #1;
    checkOutput("midreset_state", {27'd0, State}, {27'd0, ST_RESET});
    checkOutput("midreset_clrpc", {30'd0, ClrPC, MFA}, 32'd0);
    #1 Clr = 1'b1;
    MFC = 1'b1;
    expectState("midreset_f0", ST_F0);
    checkOutput("midreset_mare", {31'd0, MARE}, 32'd1);

    // ST zero-wait
    applyStimulus(32'hC2206004, 32'h20, 1'b1, 1'b0);
    fetchSeq("st");
    expectState("st0", ST_ST0);
    expectState("st1", ST_ST1);
    checkOutput("st1_sel", {28'd0, MDRE, RA_SEL, MDR_SEL}, {28'd0, 1'b1, 1'b1, 2'b01});
    expectState("st2", ST_ST2);
    checkOutput("st2_mfa", {31'd0, MFA}, 32'd1);
    expectState("st_adv", ST_ADV);
    expectState("st_back", ST_F0);

    // Illegal opcode with traps enabled and supervisor set
    applyStimulus(32'hC0080000, 32'hA0, 1'b1, 1'b0);
    fetchSeq("ill");
    checkOutput("ill_tq", {25'd0, tQE, tQ_IN}, {25'd0, 1'b1, 6'b000010});
    expectState("trap0", ST_T0);
    checkOutput("trap0_sel", {27'd0, RFE, RC_SEL, CIN_SEL}, {27'd0, 1'b1, 2'b10, 2'b00});
    expectState("trap1", ST_T1);
    checkOutput("trap1_sel", {27'd0, TBRE, RC_SEL, CIN_SEL}, {27'd0, 1'b1, 2'b01, 2'b01});
    expectState("trap2", ST_T2);
    checkOutput("trap2_sel", {26'd0, nPC_SEL, PSRE, PSR_SUPER, PSR_PREV_SUP, tQClr},
                {26'd0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0});
    expectState("trap3", ST_T3);
    checkOutput("trap3_adv", {29'd0, PCE, nPCE, nPC_ADD}, 32'h7);
    expectState("trap_back", ST_F0);

    // Interrupt beats a simultaneous illegal opcode
    applyStimulus(32'hC0080000, 32'h20, 1'b1, 1'b1);
    fetchSeq("irq");
    checkOutput("irq_no_ill", {31'd0, tQ_IN[1]}, 32'd0);
    expectState("irq_trap0", ST_T0);
    IntReq = 1'b0;
    expectState("irq_trap1", ST_T1);
    expectState("irq_trap2", ST_T2);
    expectState("irq_trap3", ST_T3);
    expectState("irq_back", ST_F0);

    // Illegal opcode with traps disabled locks into ERROR
    applyStimulus(32'hC0080000, 32'h00, 1'b1, 1'b0);
    fetchSeq("err");
    expectState("err_st", ST_ERR);
    checkOutput("err_flag", {31'd0, Error}, 32'd1);
    expectState("err_hold", ST_ERR);
    checkOutput("err_quiet", {30'd0, RFE, PCE}, 32'd0);
    #1 Clr = 1'b0;
    #1;
    checkOutput("err_reset", {26'd0, Error, State}, {26'd0, 1'b0, ST_RESET});
    #1 Clr = 1'b1;
    expectState("err_f0", ST_F0);

`ifdef CU_MFC_TIMEOUT_EN
    // MFC stuck low in FETCH1 times out into a trap
    applyStimulus(32'h82006005, 32'h20, 1'b0, 1'b0);
    expectState("to_f1", ST_F1);
    for (int w = 0; w < 16; w++) tick();
    checkOutput("to_still_f1", {27'd0, State}, {27'd0, ST_F1});
    checkOutput("to_tq", {25'd0, tQE, tQ_IN}, {25'd0, 1'b1, 6'b000001});
    expectState("to_trap0", ST_T0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
